// File: rtl/hack_cpu_sequencer_pkg.sv
// Shared definitions for the Hack CPU sequencer: FSM state encoding and
// instruction-register field positions.
package hack_cpu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_EXECUTE = 2'd3
  } state_t;

  localparam int IS_C    = 15;
  localparam int SEL_Y   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  function automatic logic [5:0] comp_field(input logic [15:0] instr);
    return instr[COMP_HI:COMP_LO];
  endfunction

endpackage

// File: rtl/hack_cpu_sequencer_if.sv
// Program-ROM fetch handshake between the sequencer (master) and the ROM (slave).
interface hack_cpu_sequencer_if #(
  parameter int PC_W = 15
) ();

  logic            rom_req;
  logic [PC_W-1:0] rom_addr;
  logic            rom_ack;
  logic [15:0]     rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );

endinterface

// File: rtl/hack_cpu_sequencer_jump_eval.sv
// Combinational Hack jump decision: lt/eq/gt bits against the ALU sign and zero flags.
module hack_jump_eval (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  assign taken = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the Hack CPU: owns PC and IR,
// fetches from program ROM over a req/ack handshake and drives datapath controls.
module hack_cpu_sequencer
  import hack_cpu_sequencer_pkg::*;
#(
  parameter int          PC_W         = 15,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int          CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  hack_cpu_sequencer_if.master rom,
  input  logic [PC_W-1:0]      a_val,
  input  logic                 alu_zr,
  input  logic                 alu_ng,
  output logic [5:0]           alu_ctrl,
  output logic                 sel_a,
  output logic                 sel_y,
  output logic                 load_a,
  output logic                 load_d,
  output logic                 write_m,
  output logic [PC_W-1:0]      pc,
  output logic [15:0]          ir,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     instr_count
);

  state_t cur_state;
  state_t nxt_state;
  logic   jump_taken;

  hack_jump_eval u_jump_eval (
    .jump  (ir[JUMP_HI:JUMP_LO]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .taken (jump_taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:    if (run || step) nxt_state = ST_FETCH;
      ST_FETCH:   if (rom.rom_ack) nxt_state = ST_DECODE;
      ST_DECODE:  nxt_state = ST_EXECUTE;
      ST_EXECUTE: nxt_state = run ? ST_FETCH : ST_IDLE;
      default:    nxt_state = ST_IDLE;
    endcase
  end

  // Datapath controls follow IR from DECODE on so the ALU flags settle a cycle
  // before EXECUTE; the load/write strobes are confined to EXECUTE.
  always_comb begin
    rom.rom_req = 1'b0;
    alu_ctrl    = 6'd0;
    sel_a       = 1'b0;
    sel_y       = 1'b0;
    load_a      = 1'b0;
    load_d      = 1'b0;
    write_m     = 1'b0;
    case (cur_state)
      ST_FETCH: rom.rom_req = 1'b1;
      ST_DECODE: begin
        alu_ctrl = comp_field(ir);
        sel_a    = ir[IS_C];
        sel_y    = ir[SEL_Y];
      end
      ST_EXECUTE: begin
        alu_ctrl = comp_field(ir);
        sel_a    = ir[IS_C];
        sel_y    = ir[SEL_Y];
        load_a   = ~ir[IS_C] | ir[DEST_A];
        load_d   = ir[IS_C] & ir[DEST_D];
        write_m  = ir[IS_C] & ir[DEST_M];
      end
      default: ;
    endcase
  end

  // a_val is the A register before this EXECUTE's own load takes effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= PC_W'(RESET_VECTOR);
      ir          <= 16'd0;
      instr_count <= '0;
    end else begin
      if (cur_state == ST_FETCH && rom.rom_ack) begin
        ir <= rom.rom_data;
      end
      if (cur_state == ST_EXECUTE) begin
        instr_count <= instr_count + CNT_W'(1);
        pc          <= (ir[IS_C] && jump_taken) ? a_val : pc + PC_W'(1);
      end
    end
  end

  assign rom.rom_addr = pc;
  assign state        = cur_state;

endmodule
